ser_to_par: RTL



---
 rtl/hdmi_pkg.sv | 23 ++
 rtl/tmds_token_det.sv | 21 ++
 rtl/ser_to_par.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/hdmi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_pkg
// Description : Shared HDMI/TMDS definitions: character width, the four TMDS
//               control tokens and the word-alignment FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hdmi_pkg;

    localparam int WORD_W = 10;

    localparam logic [WORD_W-1:0] CTL_TOKEN_00 = 10'h354;
    localparam logic [WORD_W-1:0] CTL_TOKEN_01 = 10'h0AB;
    localparam logic [WORD_W-1:0] CTL_TOKEN_10 = 10'h154;
    localparam logic [WORD_W-1:0] CTL_TOKEN_11 = 10'h2AB;

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } align_state_t;

endpackage
`default_nettype wire

// File: rtl/tmds_token_det.sv
`default_nettype none
// ============================================================================
// Module      : tmds_token_det
// Description : Combinational match of a 10-bit TMDS character against the
//               four control tokens.
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_token_det
    import hdmi_pkg::*;
(
    input  logic [WORD_W-1:0] i_word,
    output logic              o_is_token
);

    assign o_is_token = (i_word == CTL_TOKEN_00) ||
                        (i_word == CTL_TOKEN_01) ||
                        (i_word == CTL_TOKEN_10) ||
                        (i_word == CTL_TOKEN_11);

endmodule
`default_nettype wire

// File: rtl/ser_to_par.sv
`default_nettype none
// ============================================================================
// Module      : ser_to_par
// Description : TMDS receive front end: 2-bit DDR samples to aligned 10-bit
//               characters, boundary found by control-token search.
//               Optional lock-loss counter: define SER_TO_PAR_LOSS_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ser_to_par
    import hdmi_pkg::*;
#(
    parameter int SEARCH_WORDS = 2048,
    parameter int LOCK_TOKENS  = 8,
    parameter int LOSS_WORDS   = 4096
) (
    input  logic              clk_5x,
    input  logic              sys_rst,
    input  logic              data_rise,
    input  logic              data_fall,
    output logic [WORD_W-1:0] par_data,
    output logic              par_valid,
    output logic              token_det,
    output logic              locked,
    output logic [3:0]        slip_pos,
    output logic [7:0]        lock_loss_cnt
);

    localparam int c_SR_W    = 2 * WORD_W;
    localparam int c_GAP_MAX = (SEARCH_WORDS > LOSS_WORDS) ? SEARCH_WORDS : LOSS_WORDS;
    localparam int c_GAP_W   = $clog2(c_GAP_MAX + 1);
    localparam int c_TOK_W   = $clog2(LOCK_TOKENS + 1);

    localparam logic [c_GAP_W-1:0] c_SEARCH_LAST = c_GAP_W'(SEARCH_WORDS - 1);
    localparam logic [c_GAP_W-1:0] c_LOSS_LAST   = c_GAP_W'(LOSS_WORDS - 1);
    localparam logic [c_TOK_W-1:0] c_TOK_LAST    = c_TOK_W'(LOCK_TOKENS - 1);
    localparam logic [3:0]         c_SLIP_MAX    = 4'd9;
    localparam logic [2:0]         c_PHASE_LAST  = 3'd4;

    logic [c_SR_W-1:0]  r_sr;
    logic [2:0]         r_phase;
    logic [WORD_W-1:0]  r_par_data;
    logic               r_par_valid;
    logic               r_token_det;

    align_state_t       r_state;
    align_state_t       w_state_nxt;
    logic [c_TOK_W-1:0] r_tok_cnt;
    logic [c_TOK_W-1:0] w_tok_cnt_nxt;
    logic [c_GAP_W-1:0] r_gap_cnt;
    logic [c_GAP_W-1:0] w_gap_cnt_nxt;
    logic [3:0]         r_slip_pos;
    logic [3:0]         w_slip_pos_nxt;
    logic [3:0]         w_slip_inc;

    logic [4:0]         w_sel;
    logic [WORD_W-1:0]  w_window;
    logic               w_window_is_token;

    // Oldest bit sits at sr[0]; slip_pos picks which of the ten bit offsets
    // is treated as the character boundary.
    assign w_sel    = {1'b0, r_slip_pos};
    assign w_window = r_sr[w_sel +: WORD_W];

    tmds_token_det u_token_det (
        .i_word     (w_window),
        .o_is_token (w_window_is_token)
    );

    always_ff @(posedge clk_5x) begin
        if (sys_rst) begin
            r_sr        <= '0;
            r_phase     <= '0;
            r_par_data  <= '0;
            r_par_valid <= 1'b0;
            r_token_det <= 1'b0;
        end else begin
            r_sr        <= {data_fall, data_rise, r_sr[c_SR_W-1:2]};
            r_par_valid <= (r_phase == c_PHASE_LAST);
            if (r_phase == c_PHASE_LAST) begin
                r_phase     <= '0;
                r_par_data  <= w_window;
                r_token_det <= w_window_is_token;
            end else begin
                r_phase <= r_phase + 3'd1;
            end
        end
    end

    assign w_slip_inc = (r_slip_pos == c_SLIP_MAX) ? 4'd0 : r_slip_pos + 4'd1;

    always_ff @(posedge clk_5x) begin
        if (sys_rst) begin
            r_state    <= ST_SEARCH;
            r_tok_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_slip_pos <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tok_cnt  <= w_tok_cnt_nxt;
            r_gap_cnt  <= w_gap_cnt_nxt;
            r_slip_pos <= w_slip_pos_nxt;
        end
    end

    // Alignment FSM advances once per delivered word.
    always_comb begin
        w_state_nxt    = r_state;
        w_tok_cnt_nxt  = r_tok_cnt;
        w_gap_cnt_nxt  = r_gap_cnt;
        w_slip_pos_nxt = r_slip_pos;
        if (r_par_valid) begin
            case (r_state)
                ST_SEARCH: begin
                    if (r_token_det) begin
                        w_gap_cnt_nxt = '0;
                        if (r_tok_cnt == c_TOK_LAST) begin
                            w_tok_cnt_nxt = '0;
                            w_state_nxt   = ST_LOCKED;
                        end else begin
                            w_tok_cnt_nxt = r_tok_cnt + 1'b1;
                        end
                    end else begin
                        w_tok_cnt_nxt = '0;
                        if (r_gap_cnt == c_SEARCH_LAST) begin
                            w_gap_cnt_nxt  = '0;
                            w_slip_pos_nxt = w_slip_inc;
                        end else begin
                            w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (r_token_det) begin
                        w_gap_cnt_nxt = '0;
                    end else if (r_gap_cnt == c_LOSS_LAST) begin
                        w_state_nxt    = ST_SEARCH;
                        w_slip_pos_nxt = w_slip_inc;
                        w_tok_cnt_nxt  = '0;
                        w_gap_cnt_nxt  = '0;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_SEARCH;
                end
            endcase
        end
    end

`ifdef SER_TO_PAR_LOSS_CNT_EN
    logic       w_lock_drop;
    logic [7:0] r_lock_loss_cnt;

    assign w_lock_drop = r_par_valid && (r_state == ST_LOCKED) &&
                         !r_token_det && (r_gap_cnt == c_LOSS_LAST);

    always_ff @(posedge clk_5x) begin
        if (sys_rst) begin
            r_lock_loss_cnt <= '0;
        end else if (w_lock_drop && (r_lock_loss_cnt != 8'hFF)) begin
            r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
        end
    end

    assign lock_loss_cnt = r_lock_loss_cnt;
`else
    assign lock_loss_cnt = 8'd0;
`endif

    assign par_data  = r_par_data;
    assign par_valid = r_par_valid;
    assign token_det = r_token_det;
    assign locked    = (r_state == ST_LOCKED);
    assign slip_pos  = r_slip_pos;

endmodule
`default_nettype wire
